// File: rtl/lsu_store_buffer_if.sv
// Request/response bus between the CPU memory stage and the load/store unit.
// The master drives requests and consumes responses. The slave is the LSU.
interface lsu_store_buffer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              excp_adel;
    logic              excp_ades;
    logic [ADDR_W-1:0] excp_badvaddr;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, excp_adel, excp_ades, excp_badvaddr
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, excp_adel, excp_ades, excp_badvaddr
    );
endinterface

// File: rtl/lsu_store_buffer.sv
// Data-side load/store unit. Stores are lane-aligned into a small FIFO that
// drains to SRAM whenever no load needs the port. Loads read SRAM directly
// and stall while a buffered store targets the same word. Misaligned or
// illegal requests complete with an exception and never touch SRAM.
module lsu_store_buffer #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int SB_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    lsu_store_buffer_if.slave             bus,
    output logic                          sram_en_o,
    output logic [DATA_W/8-1:0]           sram_wen_o,
    output logic [ADDR_W-1:0]             sram_addr_o,
    output logic [DATA_W-1:0]             sram_wdata_o,
    input  logic [DATA_W-1:0]             sram_rdata_i,
    output logic [$clog2(SB_DEPTH):0]     sb_count_o
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Store buffer storage and bookkeeping
    logic [ADDR_W-1:0] sb_addr_q [SB_DEPTH];
    logic [NB-1:0]     sb_mask_q [SB_DEPTH];
    logic [DATA_W-1:0] sb_data_q [SB_DEPTH];
    logic [SB_DEPTH-1:0] sb_valid_q;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Response pipeline (one-cycle latency)
    logic              resp_valid_q, resp_load_q, adel_q, ades_q, signed_q;
    logic [ADDR_W-1:0] badv_q;
    logic [OFF_W-1:0]  off_q;
    logic [1:0]        size_q;

    logic [OFF_W-1:0]  req_off;
    logic [ADDR_W-1:0] req_waddr;
    logic              misaligned, hazard, full, accept, store_fire, load_fire, drain;
    logic [SB_DEPTH-1:0] match;
    logic [NB-1:0]     lane_keep, st_mask;
    logic [DATA_W-1:0] st_wdata_keep, st_data;
    logic [DATA_W-1:0] load_shifted, load_ext;
    logic              sign_bit;
    int                load_bits;

    assign req_off   = bus.req_addr[OFF_W-1:0];
    assign req_waddr = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Alignment rules per access size; dword exists only on a 64-bit path
    always_comb begin
        misaligned = 1'b0;
        case (bus.req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = bus.req_addr[0];
            2'd2:    misaligned = |bus.req_addr[1:0];
            default: misaligned = (DATA_W == 32) ? 1'b1 : |bus.req_addr[2:0];
        endcase
    end

    // Word-address match of every live buffer entry against the request
    genvar gi;
    generate
        for (gi = 0; gi < SB_DEPTH; gi++) begin : g_match
            assign match[gi] = sb_valid_q[gi] && (sb_addr_q[gi] == req_waddr);
        end
    endgenerate

    assign hazard     = |match;
    assign full       = (count_q == CNT_W'(SB_DEPTH));
    assign bus.req_ready = ~rst & (bus.req_we ? ~full : ~hazard);
    assign accept     = bus.req_valid & bus.req_ready;
    assign store_fire = accept & bus.req_we & ~misaligned;
    assign load_fire  = accept & ~bus.req_we & ~misaligned;
    // Loads own the SRAM port; otherwise the head entry drains
    assign drain      = ~rst & ~load_fire & (count_q != '0);

    // Bytes covered by the access size, before shifting to the lane offset
    always_comb begin
        lane_keep = '0;
        for (int b = 0; b < NB; b++) begin
            lane_keep[b] = (b < (1 << bus.req_size));
        end
    end

    // Zero the store bytes above the access size so they never reach SRAM
    generate
        for (gi = 0; gi < NB; gi++) begin : g_keep
            assign st_wdata_keep[8*gi +: 8] = lane_keep[gi] ? bus.req_wdata[8*gi +: 8] : 8'h00;
        end
    endgenerate

    assign st_mask = lane_keep << req_off;
    assign st_data = st_wdata_keep << {req_off, 3'b000};

    // Pointer and occupancy next-state; pointers wrap naturally at SB_DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (store_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (drain)      rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (store_fire && !drain)      count_d = count_q + CNT_W'(1);
        else if (drain && !store_fire) count_d = count_q - CNT_W'(1);
    end

    // FIFO state: enqueue at the accepting edge, pop at the draining edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_valid_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            if (store_fire) begin
                sb_addr_q[wr_ptr_q]  <= req_waddr;
                sb_mask_q[wr_ptr_q]  <= st_mask;
                sb_data_q[wr_ptr_q]  <= st_data;
                sb_valid_q[wr_ptr_q] <= 1'b1;
            end
            if (drain) sb_valid_q[rd_ptr_q] <= 1'b0;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Capture everything the response cycle needs at the accepting edge
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_load_q  <= 1'b0;
            adel_q       <= 1'b0;
            ades_q       <= 1'b0;
            badv_q       <= '0;
            off_q        <= '0;
            size_q       <= '0;
            signed_q     <= 1'b0;
        end else begin
            resp_valid_q <= accept;
            resp_load_q  <= load_fire;
            adel_q       <= accept & ~bus.req_we & misaligned;
            ades_q       <= accept & bus.req_we & misaligned;
            badv_q       <= (accept & misaligned) ? bus.req_addr : '0;
            if (load_fire) begin
                off_q    <= req_off;
                size_q   <= bus.req_size;
                signed_q <= bus.req_signed;
            end
        end
    end

    // Extract the addressed bytes of the returned word and extend them
    always_comb begin
        load_shifted = sram_rdata_i >> {off_q, 3'b000};
        case (size_q)
            2'd0:    begin load_bits = 8;      sign_bit = load_shifted[7];        end
            2'd1:    begin load_bits = 16;     sign_bit = load_shifted[15];       end
            2'd2:    begin load_bits = 32;     sign_bit = load_shifted[31];       end
            default: begin load_bits = DATA_W; sign_bit = load_shifted[DATA_W-1]; end
        endcase
        load_ext = '0;
        for (int i = 0; i < DATA_W; i++) begin
            load_ext[i] = (i < load_bits) ? load_shifted[i] : (signed_q & sign_bit);
        end
    end

    assign bus.resp_valid    = resp_valid_q & ~rst;
    assign bus.resp_rdata    = (resp_valid_q & resp_load_q & ~rst) ? load_ext : '0;
    assign bus.excp_adel     = adel_q & ~rst;
    assign bus.excp_ades     = ades_q & ~rst;
    assign bus.excp_badvaddr = rst ? '0 : badv_q;

    assign sram_en_o    = load_fire | drain;
    assign sram_wen_o   = drain ? sb_mask_q[rd_ptr_q] : '0;
    assign sram_addr_o  = load_fire ? req_waddr : (drain ? sb_addr_q[rd_ptr_q] : '0);
    assign sram_wdata_o = drain ? sb_data_q[rd_ptr_q] : '0;
    assign sb_count_o   = rst ? '0 : count_q;
endmodule

// File: tb/tb_lsu_store_buffer.sv
// Bench for lsu_store_buffer: a queue/array reference model checked every
// cycle on a 32-bit instance, directed literal cases, and a few directed
// cases on a 64-bit instance.
`timescale 1ns/1ps
module tb_lsu_store_buffer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst64;

    lsu_store_buffer_if #(.DATA_W(32), .ADDR_W(32)) bus32 ();
    lsu_store_buffer_if #(.DATA_W(64), .ADDR_W(32)) bus64 ();

    logic        s_en;
    logic [3:0]  s_wen;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [2:0]  s_cnt;
    logic        t_en;
    logic [7:0]  t_wen;
    logic [31:0] t_addr;
    logic [63:0] t_wdata, t_rdata;
    logic [2:0]  t_cnt;

    lsu_store_buffer #(.DATA_W(32), .ADDR_W(32), .SB_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bus(bus32),
        .sram_en_o(s_en), .sram_wen_o(s_wen), .sram_addr_o(s_addr),
        .sram_wdata_o(s_wdata), .sram_rdata_i(s_rdata), .sb_count_o(s_cnt));

    lsu_store_buffer #(.DATA_W(64), .ADDR_W(32), .SB_DEPTH(4)) dut64 (
        .clk(clk), .rst(rst64), .bus(bus64),
        .sram_en_o(t_en), .sram_wen_o(t_wen), .sram_addr_o(t_addr),
        .sram_wdata_o(t_wdata), .sram_rdata_i(t_rdata), .sb_count_o(t_cnt));

    int n_checks = 0;
    int n_fail   = 0;
    int en_cnt   = 0;

    typedef struct { logic [31:0] addr; logic [3:0] mask; logic [31:0] data; } sb_ent_t;
    typedef struct { logic [3:0] wen; logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic [31:0] rd; logic adel; logic ades; logic [31:0] badv; } resp_t;

    sb_ent_t sbq[$];
    wr_t     wq[$];
    resp_t   rq[$];
    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] phys_mem  [logic [31:0]];

    // expected response for the current cycle
    logic        pv = 1'b0, pl = 1'b0, ps = 1'b0;
    logic [31:0] prd = '0, pb = '0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] init_word(logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [31:0] mread(logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] pread(logic [31:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
    endfunction

    function automatic logic mis32(logic [1:0] sz, logic [31:0] a);
        case (sz)
            2'd0:    return 1'b0;
            2'd1:    return a[0];
            2'd2:    return a[1:0] != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] load_val(logic [31:0] w, logic [1:0] sz, logic sg, logic [1:0] off);
        logic [63:0] v, m;
        int nb;
        nb = 8 * (1 << sz);
        m  = (64'd1 << nb) - 64'd1;
        v  = (64'(w) >> (8 * off)) & m;
        if (sg && v[nb-1]) v = v | ~m;
        return v[31:0];
    endfunction

    // SRAM behind the 32-bit instance: registered read, byte-enabled write
    always @(posedge clk) begin
        logic [31:0] w;
        if (s_en && s_wen == 4'd0) begin
            s_rdata <= pread(s_addr);
        end else begin
            s_rdata <= $urandom;
            if (s_en) begin
                w = pread(s_addr);
                for (int b = 0; b < 4; b++)
                    if (s_wen[b]) w[8*b +: 8] = s_wdata[8*b +: 8];
                phys_mem[s_addr] = w;
            end
        end
    end

    // Observation queues for directed checks
    always @(negedge clk) begin
        if (!rst) begin
            if (s_en) en_cnt++;
            if (s_en && s_wen != 4'd0) wq.push_back('{s_wen, s_addr, s_wdata});
            if (bus32.resp_valid)
                rq.push_back('{bus32.resp_rdata, bus32.excp_adel, bus32.excp_ades, bus32.excp_badvaddr});
        end
    end

    // Reference model and per-cycle compare for the 32-bit instance
    always @(negedge clk) begin
        int cnt, nbytes;
        logic [31:0] wa, w;
        logic [1:0]  off;
        logic rdy, acc, lf, dr, m;
        sb_ent_t h, e;
        if (rst) begin
            chk("rst_req_ready", bus32.req_ready, 0);
            chk("rst_resp_valid", bus32.resp_valid, 0);
            chk("rst_sram_en", s_en, 0);
            chk("rst_sb_count", s_cnt, 0);
            chk("rst_badvaddr", bus32.excp_badvaddr, 0);
            sbq.delete();
            pv = 1'b0;
        end else begin
            cnt = sbq.size();
            wa  = {bus32.req_addr[31:2], 2'b00};
            off = bus32.req_addr[1:0];
            m   = mis32(bus32.req_size, bus32.req_addr);
            if (bus32.req_we) begin
                rdy = (cnt < 4);
            end else begin
                rdy = 1'b1;
                foreach (sbq[i]) if (sbq[i].addr == wa) rdy = 1'b0;
            end
            acc = bus32.req_valid && rdy;
            lf  = acc && !bus32.req_we && !m;
            dr  = !lf && (cnt > 0);

            if (bus32.req_valid) chk("req_ready", bus32.req_ready, rdy);
            chk("sram_en", s_en, lf || dr);
            if (lf) begin
                chk("read_wen", s_wen, 0);
                chk("read_addr", s_addr, wa);
            end else if (dr) begin
                chk("drain_wen", s_wen, sbq[0].mask);
                chk("drain_addr", s_addr, sbq[0].addr);
                chk("drain_wdata", s_wdata, sbq[0].data);
            end else begin
                chk("idle_wen", s_wen, 0);
            end
            chk("sb_count", s_cnt, cnt);
            chk("resp_valid", bus32.resp_valid, pv);
            chk("resp_rdata", bus32.resp_rdata, pv ? prd : 32'd0);
            chk("excp_adel", bus32.excp_adel, pv & pl);
            chk("excp_ades", bus32.excp_ades, pv & ps);
            chk("excp_badvaddr", bus32.excp_badvaddr, pv ? pb : 32'd0);

            if (dr) begin
                h = sbq.pop_front();
                w = mread(h.addr);
                for (int b = 0; b < 4; b++)
                    if (h.mask[b]) w[8*b +: 8] = h.data[8*b +: 8];
                model_mem[h.addr] = w;
            end
            if (acc && bus32.req_we && !m) begin
                nbytes = 1 << bus32.req_size;
                e.addr = wa;
                e.mask = 4'(((1 << nbytes) - 1) << off);
                e.data = 32'((64'(bus32.req_wdata) & ((64'd1 << (8 * nbytes)) - 64'd1)) << (8 * off));
                sbq.push_back(e);
            end
            pv  = acc;
            prd = lf ? load_val(mread(wa), bus32.req_size, bus32.req_signed, off) : 32'd0;
            pl  = acc && !bus32.req_we && m;
            ps  = acc && bus32.req_we && m;
            pb  = (acc && m) ? bus32.req_addr : 32'd0;
        end
    end

    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, output int waits);
        waits = 0;
        bus32.req_valid = 1'b1; bus32.req_we = we; bus32.req_size = sz;
        bus32.req_signed = sg; bus32.req_addr = a; bus32.req_wdata = wd;
        @(negedge clk);
        while (!bus32.req_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        chk("issue_wait_bound", 64'(waits < 50), 1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus32.req_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic issue64(input logic we, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [63:0] wd);
        int waits = 0;
        bus64.req_valid = 1'b1; bus64.req_we = we; bus64.req_size = sz;
        bus64.req_signed = sg; bus64.req_addr = a; bus64.req_wdata = wd;
        @(negedge clk);
        while (!bus64.req_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        chk("issue64_wait_bound", 64'(waits < 50), 1);
        @(posedge clk); #1;
        bus64.req_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int waits, en0;
        logic [31:0] ra;
        rst = 1'b1; rst64 = 1'b1;
        bus32.req_valid = 1'b0; bus32.req_we = 1'b0; bus32.req_size = 2'd0;
        bus32.req_signed = 1'b0; bus32.req_addr = '0; bus32.req_wdata = '0;
        bus64.req_valid = 1'b0; bus64.req_we = 1'b0; bus64.req_size = 2'd0;
        bus64.req_signed = 1'b0; bus64.req_addr = '0; bus64.req_wdata = '0;
        t_rdata = 64'h80000000_12345678;
        model_mem[32'h2000] = 32'h80011234;
        phys_mem[32'h2000]  = 32'h80011234;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("reset_sb_count", s_cnt, 0);
        chk("reset_req_ready", bus32.req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0; rst64 = 1'b0;
        idle(2);

        // store byte: drained into lane 1 of word 0x1000
        wq.delete(); rq.delete();
        issue(1'b1, 2'd0, 1'b0, 32'h1001, 32'h000000A5, waits);
        idle(3);
        chk("t1_nwrites", wq.size(), 1);
        if (wq.size() > 0) begin
            chk("t1_wen", wq[0].wen, 4'b0010);
            chk("t1_addr", wq[0].addr, 32'h1000);
            chk("t1_wdata", wq[0].data, 32'h0000A500);
        end
        chk("t1_nresp", rq.size(), 1);

        // loads with extension from word 0x80011234
        wq.delete(); rq.delete();
        issue(1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, waits);
        issue(1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, waits);
        issue(1'b0, 2'd0, 1'b1, 32'h2001, 32'h0, waits);
        idle(2);
        chk("t2_nresp", rq.size(), 3);
        if (rq.size() == 3) begin
            chk("t2_lh", rq[0].rd, 32'hFFFF8001);
            chk("t2_lhu", rq[1].rd, 32'h00008001);
            chk("t2_lb", rq[2].rd, 32'h00000012);
        end

        // load right behind a store to the same word stalls until drained
        wq.delete(); rq.delete();
        issue(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, waits);
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, waits);
        chk("t3_stall_cycles", waits, 1);
        idle(2);
        chk("t3_nresp", rq.size(), 2);
        if (rq.size() == 2) begin
            chk("t3_sw_rdata", rq[0].rd, 32'h0);
            chk("t3_lw_rdata", rq[1].rd, 32'hDEADBEEF);
        end
        if (wq.size() > 0) chk("t3_write_addr", wq[0].addr, 32'h100);

        // interleaved stores and loads: drains in issue order
        wq.delete(); rq.delete();
        for (int k = 0; k < 5; k++) begin
            issue(1'b1, 2'd2, 1'b0, 32'h400 + 32'(4 * k), 32'hC0DE0000 + 32'(k), waits);
            issue(1'b0, 2'd2, 1'b0, 32'h500 + 32'(4 * k), 32'h0, waits);
        end
        idle(4);
        chk("t4_nwrites", wq.size(), 5);
        for (int k = 0; k < 5; k++)
            if (k < wq.size()) chk("t4_drain_order", wq[k].addr, 32'h400 + 32'(4 * k));
        chk("t4_empty", s_cnt, 0);

        // misaligned load and store raise exceptions without SRAM access
        wq.delete(); rq.delete();
        en0 = en_cnt;
        issue(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, waits);
        idle(2);
        chk("t5_no_sram", en_cnt - en0, 0);
        if (rq.size() > 0) begin
            chk("t5_adel", rq[0].adel, 1);
            chk("t5_badv_load", rq[0].badv, 32'h102);
            chk("t5_rdata0", rq[0].rd, 32'h0);
        end
        rq.delete();
        issue(1'b1, 2'd1, 1'b0, 32'h103, 32'h1234, waits);
        idle(2);
        chk("t5_no_sram_st", en_cnt - en0, 0);
        if (rq.size() > 0) begin
            chk("t5_ades", rq[0].ades, 1);
            chk("t5_badv_store", rq[0].badv, 32'h103);
        end

        // randomized traffic against the model, with occasional reset
        for (int c = 0; c < 3000; c++) begin
            ra = 32'h300 + (32'($urandom_range(0, 3)) << 2) + 32'($urandom_range(0, 3));
            bus32.req_valid  = ($urandom_range(0, 9) < 7);
            bus32.req_we     = 1'($urandom_range(0, 1));
            bus32.req_size   = 2'($urandom_range(0, 3));
            bus32.req_signed = 1'($urandom_range(0, 1));
            bus32.req_addr   = ra;
            bus32.req_wdata  = $urandom;
            rst = ($urandom_range(0, 63) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        idle(4);

        // 64-bit instance
        issue64(1'b1, 2'd3, 1'b0, 32'h8, 64'h01234567_89ABCDEF);
        @(negedge clk);
        chk("t6_sd_en", t_en, 1);
        chk("t6_sd_wen", t_wen, 8'hFF);
        chk("t6_sd_addr", t_addr, 32'h8);
        chk("t6_sd_wdata", t_wdata, 64'h01234567_89ABCDEF);
        chk("t6_sd_resp", bus64.resp_valid, 1);
        chk("t6_sd_ades", bus64.excp_ades, 0);
        step();
        issue64(1'b1, 2'd3, 1'b0, 32'hC, 64'h55);
        @(negedge clk);
        chk("t6_mis_resp", bus64.resp_valid, 1);
        chk("t6_mis_ades", bus64.excp_ades, 1);
        chk("t6_mis_badv", bus64.excp_badvaddr, 32'hC);
        chk("t6_mis_no_sram", t_en, 0);
        step();
        issue64(1'b0, 2'd2, 1'b1, 32'h14, 64'h0);
        @(negedge clk);
        chk("t6_lw_signed", bus64.resp_rdata, 64'hFFFFFFFF_80000000);
        step();
        issue64(1'b0, 2'd3, 1'b0, 32'h10, 64'h0);
        @(negedge clk);
        chk("t6_ld", bus64.resp_rdata, 64'h80000000_12345678);
        step();
        issue64(1'b1, 2'd1, 1'b0, 32'h22, 64'h1234);
        rst64 = 1'b1;
        @(negedge clk);
        chk("t6_rst_en", t_en, 0);
        chk("t6_rst_cnt", t_cnt, 0);
        chk("t6_rst_resp", bus64.resp_valid, 0);
        step();
        rst64 = 1'b0;
        @(negedge clk);
        chk("t6_post_rst_en", t_en, 0);
        chk("t6_post_rst_cnt", t_cnt, 0);
        step();
        @(negedge clk);
        chk("t6_no_late_write", t_en, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
